// File: rtl/mem_arb_pkg.sv
// Shared types and counter widths for the memory port arbiter.
//   arb_state_e  : IDLE (no access in flight) / WAIT (access outstanding)
//   arb_owner_e  : which requester owns the outstanding access
//   LAT_CNT_W    : width of the read-latency counter (MEM_LATENCY up to 7)
//   STARVE_CNT_W : width of the starvation counter (STARVE_MAX up to 15)
package mem_arb_pkg;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} arb_state_e;
  typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} arb_owner_e;

  localparam int LAT_CNT_W    = 3;
  localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating starvation counter: counts data grants made while fetch waits.
//   clk, rst       : clock, synchronous active-high reset
//   fetch_pending  : if_req seen during the arbitration cycle
//   data_grant     : data port granted this cycle
//   fetch_grant    : fetch port granted this cycle
//   starve_full    : counter has reached STARVE_MAX, fetch must win next
module arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic fetch_pending,
  input  logic data_grant,
  input  logic fetch_grant,
  output logic starve_full
);

  localparam logic [STARVE_CNT_W-1:0] CNT_MAX = STARVE_CNT_W'(STARVE_MAX);

  logic [STARVE_CNT_W-1:0] cnt;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (fetch_grant) begin
      cnt <= '0;
    end else if (data_grant) begin
      // A data grant with no fetch waiting is not starving anyone.
      if (!fetch_pending)      cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
    end
  end

  assign starve_full = (cnt == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch unit and the LSU.
// Data has priority unless fetch has been starved STARVE_MAX times in a row.
// Responses return MEM_LATENCY cycles after the grant and are routed to the
// owner recorded at grant; a new grant may overlap the response cycle.
//   clk, rst                     : clock, synchronous active-high reset
//   if_req/if_addr               : fetch request (held until if_gnt)
//   if_gnt/if_rvalid/if_rdata    : fetch accept pulse and read response
//   d_req/d_we/d_be/d_addr/d_wdata : data request (held until d_gnt)
//   d_gnt/d_rvalid/d_rdata       : data accept pulse and response (0 for store)
//   mem_en/we/be/addr/wdata      : memory port, valid in the grant cycle
//   mem_rdata                    : memory read data, MEM_LATENCY after mem_en
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_LATENCY   = 1,
  parameter int STARVE_MAX    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_req,
  input  logic [ADDRESS_WIDTH-1:0] if_addr,
  output logic                     if_gnt,
  output logic                     if_rvalid,
  output logic [DATA_WIDTH-1:0]    if_rdata,
  input  logic                     d_req,
  input  logic                     d_we,
  input  logic [DATA_WIDTH/8-1:0]  d_be,
  input  logic [ADDRESS_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0]    d_wdata,
  output logic                     d_gnt,
  output logic                     d_rvalid,
  output logic [DATA_WIDTH-1:0]    d_rdata,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [DATA_WIDTH/8-1:0]  mem_be,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
);

  localparam logic [LAT_CNT_W-1:0] LAT_LAST = LAT_CNT_W'(MEM_LATENCY - 1);

  arb_state_e             state, state_nxt;
  arb_owner_e             owner;
  logic                   we_q;
  logic [LAT_CNT_W-1:0]   lat_cnt;
  logic                   resp;
  logic                   can_grant;
  logic                   starve_full;
  logic                   grant_d, grant_if;

  // Response cycle doubles as the next grant opportunity. Everything is
  // masked during reset so no stale response or grant escapes.
  assign resp      = !rst && (state == WAIT) && (lat_cnt == LAT_LAST);
  assign can_grant = !rst && ((state == IDLE) || resp);
  assign grant_d   = can_grant && d_req && !(starve_full && if_req);
  assign grant_if  = can_grant && if_req && !grant_d;

  arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk          (clk),
    .rst          (rst),
    .fetch_pending(if_req),
    .data_grant   (grant_d),
    .fetch_grant  (grant_if),
    .starve_full  (starve_full)
  );

  // State register, owner/we capture and latency counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      owner   <= OWN_IF;
      we_q    <= 1'b0;
      lat_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (grant_d || grant_if) begin
        owner   <= grant_d ? OWN_D : OWN_IF;
        we_q    <= grant_d && d_we;
        lat_cnt <= '0;
      end else if (state == WAIT) begin
        lat_cnt <= lat_cnt + 1'b1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    if (grant_d || grant_if) state_nxt = WAIT;
    else if (resp)           state_nxt = IDLE;
  end

  // Outputs: memory port from the winner, responses to the recorded owner.
  // NOTE: every output gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    if_gnt    = grant_if;
    d_gnt     = grant_d;
    mem_en    = grant_d || grant_if;
    mem_we    = grant_d && d_we;
    mem_be    = '1;
    mem_addr  = if_addr;
    mem_wdata = '0;
    if_rvalid = 1'b0;
    if_rdata  = '0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    if (grant_d) begin
      mem_addr = d_addr;
      if (d_we) begin
        mem_be    = d_be;
        mem_wdata = d_wdata;
      end
    end
    if (resp) begin
      if (owner == OWN_D) begin
        d_rvalid = 1'b1;
        d_rdata  = we_q ? '0 : mem_rdata;
      end else begin
        if_rvalid = 1'b1;
        if_rdata  = mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with MEM_LATENCY=1 and
// one with MEM_LATENCY=3, both fed from the same stimulus.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        d_req, d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata, mem_rdata;

  logic        a_if_gnt, a_if_rvalid, a_d_gnt, a_d_rvalid, a_mem_en, a_mem_we;
  logic [31:0] a_if_rdata, a_d_rdata, a_mem_addr, a_mem_wdata;
  logic [3:0]  a_mem_be;
  logic        b_if_gnt, b_if_rvalid, b_d_gnt, b_d_rvalid, b_mem_en, b_mem_we;
  logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata;
  logic [3:0]  b_mem_be;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LATENCY(1), .STARVE_MAX(4)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(a_if_gnt),
    .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_be(a_mem_be),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.MEM_LATENCY(3), .STARVE_MAX(4)) dut3 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(b_if_gnt),
    .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_be(b_mem_be),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_tests++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling.
  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_be = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;

    // Reset: outputs idle even with a request present.
    tick();
    if_req = 1'b1; if_addr = 32'h10;
    settle();
    check("rst_if_gnt", 32'(a_if_gnt), 0);
    check("rst_mem_en", 32'(a_mem_en), 0);
    check("rst_mem_we", 32'(a_mem_we), 0);
    check("rst_if_rvalid", 32'(a_if_rvalid), 0);
    check("rst_d_rdata", a_d_rdata, 0);

    // 1. Single fetch, latency 1.
    tick();
    rst = 1'b0;
    settle();
    check("t1_if_gnt", 32'(a_if_gnt), 1);
    check("t1_mem_en", 32'(a_mem_en), 1);
    check("t1_mem_addr", a_mem_addr, 32'h10);
    check("t1_mem_be", 32'(a_mem_be), 32'hF);
    check("t1_d_gnt", 32'(a_d_gnt), 0);
    tick();
    if_req = 1'b0; mem_rdata = 32'hCAFE_0001;
    settle();
    check("t1_if_rvalid", 32'(a_if_rvalid), 1);
    check("t1_if_rdata", a_if_rdata, 32'hCAFE_0001);
    check("t1_d_rvalid", 32'(a_d_rvalid), 0);
    check("t1_d_rdata", a_d_rdata, 0);
    check("t1_no_regrant", 32'(a_mem_en), 0);
    tick();
    settle();
    check("t1_idle_rvalid", 32'(a_if_rvalid), 0);

    // 2. Simultaneous requests: data first, fetch in the response cycle.
    if_req = 1'b1; if_addr = 32'h20; d_req = 1'b1; d_addr = 32'h100;
    settle();
    check("t2_d_gnt", 32'(a_d_gnt), 1);
    check("t2_if_gnt_lost", 32'(a_if_gnt), 0);
    check("t2_mem_addr_d", a_mem_addr, 32'h100);
    tick();
    d_req = 1'b0; mem_rdata = 32'h1111_2222;
    settle();
    check("t2_d_rvalid", 32'(a_d_rvalid), 1);
    check("t2_d_rdata", a_d_rdata, 32'h1111_2222);
    check("t2_if_rdata_zero", a_if_rdata, 0);
    check("t2_if_gnt", 32'(a_if_gnt), 1);
    check("t2_mem_addr_if", a_mem_addr, 32'h20);
    tick();
    if_req = 1'b0; mem_rdata = 32'h3333_4444;
    settle();
    check("t2_if_rvalid", 32'(a_if_rvalid), 1);
    check("t2_if_rdata", a_if_rdata, 32'h3333_4444);
    check("t2_d_rvalid_off", 32'(a_d_rvalid), 0);
    tick();

    // 3. Starvation: 4 data grants then 1 fetch grant, repeating.
    if_req = 1'b1; d_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      settle();
      check($sformatf("t3_d_gnt_%0d", i), 32'(a_d_gnt), (i % 5 == 4) ? 0 : 1);
      check($sformatf("t3_if_gnt_%0d", i), 32'(a_if_gnt), (i % 5 == 4) ? 1 : 0);
      tick();
    end
    if_req = 1'b0; d_req = 1'b0;
    tick();

    // 4. Store: byte enables and write data pass through; ack has zero data.
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h200;
    d_wdata = 32'hDEAD_BEEF;
    settle();
    check("t4_d_gnt", 32'(a_d_gnt), 1);
    check("t4_mem_we", 32'(a_mem_we), 1);
    check("t4_mem_be", 32'(a_mem_be), 32'h3);
    check("t4_mem_addr", a_mem_addr, 32'h200);
    check("t4_mem_wdata", a_mem_wdata, 32'hDEAD_BEEF);
    tick();
    d_req = 1'b0; d_we = 1'b0; mem_rdata = 32'h5555_5555;
    settle();
    check("t4_d_rvalid", 32'(a_d_rvalid), 1);
    check("t4_d_rdata", a_d_rdata, 0);

    // 5. Latency 3, back-to-back fetches.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    if_req = 1'b1; if_addr = 32'h0;
    settle();
    check("t5_gnt0", 32'(b_if_gnt), 1);
    check("t5_addr0", b_mem_addr, 32'h0);
    tick();
    if_addr = 32'h4;
    settle();
    check("t5_busy1_gnt", 32'(b_if_gnt), 0);
    check("t5_busy1_en", 32'(b_mem_en), 0);
    tick();
    settle();
    check("t5_busy2_gnt", 32'(b_if_gnt), 0);
    check("t5_busy2_rv", 32'(b_if_rvalid), 0);
    tick();
    mem_rdata = 32'hA0;
    settle();
    check("t5_rv0", 32'(b_if_rvalid), 1);
    check("t5_rdata0", b_if_rdata, 32'hA0);
    check("t5_gnt1", 32'(b_if_gnt), 1);
    check("t5_addr1", b_mem_addr, 32'h4);
    tick();
    if_req = 1'b0;
    settle();
    check("t5_rv_gap1", 32'(b_if_rvalid), 0);
    tick();
    settle();
    check("t5_rv_gap2", 32'(b_if_rvalid), 0);
    tick();
    mem_rdata = 32'hA4;
    settle();
    check("t5_rv1", 32'(b_if_rvalid), 1);
    check("t5_rdata1", b_if_rdata, 32'hA4);
    tick();

    // 6. Reset during an outstanding 3-cycle access drops the response.
    if_req = 1'b1; if_addr = 32'h40;
    settle();
    check("t6_gnt", 32'(b_if_gnt), 1);
    tick();
    if_req = 1'b0; rst = 1'b1;
    settle();
    check("t6_rst_gnt", 32'(b_if_gnt), 0);
    check("t6_rst_rv", 32'(b_if_rvalid), 0);
    tick();
    rst = 1'b0; if_req = 1'b1; if_addr = 32'h80;
    settle();
    check("t6_regnt", 32'(b_if_gnt), 1);
    check("t6_regnt_addr", b_mem_addr, 32'h80);
    check("t6_rv_a", 32'(b_if_rvalid), 0);
    tick();
    if_req = 1'b0;
    settle();
    check("t6_rv_b", 32'(b_if_rvalid), 0);
    tick();
    settle();
    check("t6_rv_c", 32'(b_if_rvalid), 0);
    tick();
    settle();
    check("t6_new_rv", 32'(b_if_rvalid), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
